// File: rtl/uart_mem_ctrl.sv
// uart_mem_ctrl: parses UART command bytes into RAM writes, reads and
// burst reads, and returns read data as bytes on a valid/ready port.
module uart_mem_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic [7:0]            err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_LEN,
        S_GET_DATA,
        S_WRITE,
        S_READ,
        S_SEND
    } state_t;

    localparam logic [1:0] OP_W = 2'd0;
    localparam logic [1:0] OP_R = 2'd1;
    localparam logic [1:0] OP_B = 2'd2;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [7:0]            r_cnt;
    logic                  r_tx_valid;
    logic [7:0]            r_tx_data;
    logic [7:0]            r_err_cnt;

    logic                  w_op_ok;
    logic [1:0]            w_op;
    logic                  w_hs;
    logic                  w_drop;
    logic                  w_bad;
    logic [7:0]            w_rdata_ext;

    assign w_hs     = r_tx_valid & tx_ready;
    assign w_drop   = rx_valid & ((r_state == S_WRITE) |
                                  (r_state == S_READ)  |
                                  (r_state == S_SEND));
    assign w_bad    = rx_valid & (r_state == S_IDLE) & ~w_op_ok;

    assign tx_valid  = r_tx_valid;
    assign tx_data   = r_tx_data;
    assign mem_wr    = (r_state == S_WRITE);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = (r_state != S_IDLE);
    assign err_cnt   = r_err_cnt;

    // Opcode byte decode and zero-extension of the RAM read data.
    always_comb begin
        w_op_ok     = 1'b1;
        w_op        = OP_W;
        w_rdata_ext = '0;
        w_rdata_ext[DATA_WIDTH-1:0] = mem_rdata;
        unique case (rx_data)
            8'h57:   w_op = OP_W;
            8'h52:   w_op = OP_R;
            8'h42:   w_op = OP_B;
            default: w_op_ok = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; partial commands wait forever in the GET states.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (rx_valid && w_op_ok) w_next = S_GET_ADDR;
            end
            S_GET_ADDR: begin
                if (rx_valid) begin
                    if (r_op == OP_W)      w_next = S_GET_DATA;
                    else if (r_op == OP_R) w_next = S_READ;
                    else                   w_next = S_GET_LEN;
                end
            end
            S_GET_LEN: begin
                if (rx_valid) w_next = S_READ;
            end
            S_GET_DATA: begin
                if (rx_valid) w_next = S_WRITE;
            end
            S_WRITE: w_next = S_IDLE;
            S_READ:  w_next = S_SEND;
            S_SEND: begin
                if (w_hs) w_next = (r_cnt == 8'd0) ? S_IDLE : S_READ;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Command fields: opcode, address, write data and burst count.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_op    <= OP_W;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= 8'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (rx_valid && w_op_ok) r_op <= w_op;
                end
                S_GET_ADDR: begin
                    if (rx_valid) begin
                        r_addr <= rx_data[ADDR_WIDTH-1:0];
                        if (r_op == OP_R) r_cnt <= 8'd0;
                    end
                end
                S_GET_LEN: begin
                    if (rx_valid) r_cnt <= rx_data;
                end
                S_GET_DATA: begin
                    if (rx_valid) r_wdata <= rx_data[DATA_WIDTH-1:0];
                end
                S_SEND: begin
                    if (w_hs && r_cnt != 8'd0) begin
                        r_cnt  <= r_cnt - 8'd1;
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Response byte: captured in READ, held until the consumer takes it.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'd0;
        end else if (r_state == S_READ) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_rdata_ext;
        end else if (r_state == S_SEND && w_hs) begin
            r_tx_valid <= 1'b0;
        end
    end

    // Saturating count of unknown opcodes and bytes arriving while busy.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_err_cnt <= 8'd0;
        end else if ((w_drop || w_bad) && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_mem_ctrl.sv
// tb_uart_mem_ctrl: directed vector table plus hand sequences for
// bursts, backpressure, error counting, reset and narrow widths.
module tb_uart_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       load;
    logic       rx_valid, tx_ready, tx_valid, mem_wr, busy;
    logic [7:0] rx_data, tx_data, mem_addr, mem_wdata, mem_rdata, err_cnt;

    logic       rx_valid4, tx_ready4, tx_valid4, mem_wr4, busy4;
    logic [7:0] rx_data4, tx_data4, err_cnt4;
    logic [3:0] mem_addr4, mem_wdata4, mem_rdata4;

    logic [7:0] mem8 [256];
    logic [3:0] mem4 [16];
    int         wr_cnt, wr_cnt4;
    logic [7:0] last_wa, last_wd;
    logic [3:0] last_wa4;

    int total = 0;
    int bad   = 0;

    logic [7:0] got [$];
    int         got_t [$];

    always #5 clk = ~clk;

    uart_mem_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst_l(rst_l),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .err_cnt(err_cnt)
    );

    uart_mem_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(4)) dut4 (
        .clk(clk), .rst_l(rst_l),
        .rx_valid(rx_valid4), .rx_data(rx_data4),
        .tx_valid(tx_valid4), .tx_ready(tx_ready4), .tx_data(tx_data4),
        .mem_wr(mem_wr4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
        .mem_rdata(mem_rdata4), .busy(busy4), .err_cnt(err_cnt4)
    );

    assign mem_rdata  = mem8[mem_addr];
    assign mem_rdata4 = mem4[mem_addr4];

    // RAM models, preloaded with mem[i]=i, write counters
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem8[i] <= 8'(i);
            for (int i = 0; i < 16; i++)  mem4[i] <= 4'(i);
            wr_cnt  <= 0;
            wr_cnt4 <= 0;
        end else begin
            if (mem_wr) begin
                mem8[mem_addr] <= mem_wdata;
                wr_cnt  <= wr_cnt + 1;
                last_wa <= mem_addr;
                last_wd <= mem_wdata;
            end
            if (mem_wr4) begin
                mem4[mem_addr4] <= mem_wdata4;
                wr_cnt4  <= wr_cnt4 + 1;
                last_wa4 <= mem_addr4;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b);
        @(posedge clk); #1;
        if (sel) begin
            rx_valid4 = 1'b1; rx_data4 = b;
        end else begin
            rx_valid = 1'b1; rx_data = b;
        end
        @(posedge clk); #1;
        rx_valid  = 1'b0;
        rx_valid4 = 1'b0;
    endtask

    // gather tx bytes (tx_ready high) until the DUT returns to idle
    task automatic collect();
        bit done = 0;
        got.delete();
        got_t.delete();
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (tx_valid) begin
                got.push_back(tx_data);
                got_t.push_back(c);
            end
            if (!busy) done = 1;
        end
        if (!done) chk("collect_timeout", 1, 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst_l = 1'b0;
        @(posedge clk); #1 rst_l = 1'b1;
    endtask

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         nb;
        int         ntx;
        logic [7:0] tx0;
        int         err;
        int         wr;
        logic [7:0] wa, wd;
    } vec_t;

    vec_t vt [10];

    initial begin
        logic [7:0] exp_b [4];
        logic [7:0] cap;
        bit         held;
        int         wr0;
        bit         seen;

        vt[0] = '{8'h57, 8'h05, 8'hA5, 3, 0, 8'h00, 0, 1, 8'h05, 8'hA5};
        vt[1] = '{8'h52, 8'h05, 8'h00, 2, 1, 8'hA5, 0, 1, 8'h00, 8'h00};
        vt[2] = '{8'h52, 8'h07, 8'h00, 2, 1, 8'h07, 0, 1, 8'h00, 8'h00};
        vt[3] = '{8'h57, 8'h07, 8'h3C, 3, 0, 8'h00, 0, 2, 8'h07, 8'h3C};
        vt[4] = '{8'h52, 8'h07, 8'h00, 2, 1, 8'h3C, 0, 2, 8'h00, 8'h00};
        vt[5] = '{8'h42, 8'h10, 8'h00, 3, 1, 8'h10, 0, 2, 8'h00, 8'h00};
        vt[6] = '{8'h42, 8'h20, 8'h02, 3, 3, 8'h20, 0, 2, 8'h00, 8'h00};
        vt[7] = '{8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 1, 2, 8'h00, 8'h00};
        vt[8] = '{8'h52, 8'hFF, 8'h00, 2, 1, 8'hFF, 1, 2, 8'h00, 8'h00};
        vt[9] = '{8'h41, 8'h00, 8'h00, 1, 0, 8'h00, 2, 2, 8'h00, 8'h00};

        rst_l = 1'b0; load = 1'b1;
        rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        rx_valid4 = 1'b0; rx_data4 = 8'h00; tx_ready4 = 1'b1;

        #1;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_cnt", err_cnt, 0);

        repeat (2) @(posedge clk);
        #1 load = 1'b0; rst_l = 1'b1;

        // table-driven commands
        for (int i = 0; i < 10; i++) begin
            send_byte(0, vt[i].b0);
            if (vt[i].nb > 1) send_byte(0, vt[i].b1);
            if (vt[i].nb > 2) send_byte(0, vt[i].b2);
            collect();
            chk($sformatf("v%0d_ntx", i), got.size(), vt[i].ntx);
            if (vt[i].ntx > 0 && got.size() > 0)
                chk($sformatf("v%0d_tx0", i), got[0], vt[i].tx0);
            chk($sformatf("v%0d_err", i), err_cnt, vt[i].err);
            chk($sformatf("v%0d_wrcnt", i), wr_cnt, vt[i].wr);
            if (vt[i].b0 == 8'h57) begin
                chk($sformatf("v%0d_waddr", i), last_wa, vt[i].wa);
                chk($sformatf("v%0d_wdata", i), last_wd, vt[i].wd);
            end
        end

        // burst with address wrap
        exp_b[0] = 8'hFE; exp_b[1] = 8'hFF;
        exp_b[2] = 8'h00; exp_b[3] = 8'h01;
        send_byte(0, 8'h42); send_byte(0, 8'hFE); send_byte(0, 8'h03);
        collect();
        chk("burst_cnt", got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++)
            chk($sformatf("burst_b%0d", k), got[k], exp_b[k]);
        for (int k = 1; k < got.size(); k++)
            chk($sformatf("burst_gap%0d", k), got_t[k] - got_t[k-1], 2);
        chk("burst_busy", busy, 0);

        // errors, backpressure hold, byte dropped on handshake
        pulse_reset();
        send_byte(0, 8'h00); send_byte(0, 8'h99);
        chk("err_two", err_cnt, 2);
        tx_ready = 1'b0;
        send_byte(0, 8'h52); send_byte(0, 8'h05);
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (tx_valid) seen = 1;
        end
        chk("hold_seen", seen, 1);
        held = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!(tx_valid === 1'b1 && tx_data === 8'hA5 &&
                  mem_wr === 1'b0 && mem_addr === 8'h05))
                held = 0;
        end
        chk("hold_stable", held, 1);
        send_byte(0, 8'h11); send_byte(0, 8'h22);
        chk("err_pending", err_cnt, 4);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = 8'h33; tx_ready = 1'b1;
        @(negedge clk);
        chk("hs_valid", tx_valid, 1);
        cap = tx_data;
        @(posedge clk); #1 rx_valid = 1'b0;
        @(negedge clk);
        chk("hs_data", cap, 8'hA5);
        chk("hs_cleared", tx_valid, 0);
        chk("hs_busy", busy, 0);
        chk("err_five", err_cnt, 5);

        // reset in the middle of a write command
        wr0 = wr_cnt;
        send_byte(0, 8'h57); send_byte(0, 8'h10);
        #3 rst_l = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_addr", mem_addr, 0);
        chk("mid_err", err_cnt, 0);
        chk("mid_wr", mem_wr, 0);
        @(posedge clk); #1 rst_l = 1'b1;
        repeat (5) @(posedge clk);
        chk("mid_nowrite", wr_cnt, wr0);
        send_byte(0, 8'h52); send_byte(0, 8'h10);
        collect();
        chk("mid_read_n", got.size(), 1);
        if (got.size() > 0) chk("mid_read", got[0], 8'h10);

        // reset while a response byte is pending
        tx_ready = 1'b0;
        send_byte(0, 8'h52); send_byte(0, 8'h07);
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (tx_valid) seen = 1;
        end
        chk("pend_seen", seen, 1);
        #2 rst_l = 1'b0;
        #1;
        chk("pend_drop", tx_valid, 0);
        chk("pend_data", tx_data, 0);
        @(posedge clk); #1 rst_l = 1'b1; tx_ready = 1'b1;

        // error counter saturation
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = 8'h11;
        repeat (200) @(posedge clk);
        #1 chk("err_200", err_cnt, 200);
        repeat (100) @(posedge clk);
        #1 rx_valid = 1'b0;
        chk("err_sat", err_cnt, 255);

        // narrow 4-bit instance
        send_byte(1, 8'h57); send_byte(1, 8'hF3); send_byte(1, 8'hBC);
        repeat (3) @(posedge clk);
        #1;
        chk("n4_wrcnt", wr_cnt4, 1);
        chk("n4_waddr", last_wa4, 4'h3);
        chk("n4_mem", mem4[3], 4'hC);
        send_byte(1, 8'h52); send_byte(1, 8'h03);
        seen = 0;
        cap  = 8'hEE;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (tx_valid4) begin
                seen = 1;
                cap  = tx_data4;
            end
        end
        chk("n4_seen", seen, 1);
        chk("n4_tx", cap, 8'h0C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_mem_ctrl.md
# uart_mem_ctrl

Command-driven memory initiator that sits between the UART byte stream and the single-port RAM. Parses received bytes into write, read and burst-read commands, drives the RAM's `wr`/`addr`/`wdata` port, samples `rdata`, and returns read data as bytes on a valid/ready transmit interface. It is the bus master for the RAM's access port.

## Interface
- `ADDR_WIDTH`, 8, RAM address width; must be 1..8 (address carried in one byte).
- `DATA_WIDTH`, 8, RAM data width; must be 1..8 (data carried in one byte).
- `clk`  in  1  clock, all state on rising edge.
- `rst_l`  in  1  reset, asynchronous, active-low.
- `rx_valid`  in  1  one-cycle strobe per received byte; no backpressure.
- `rx_data`  in  8  received byte, valid with `rx_valid`.
- `tx_valid`  out  1  response byte available.
- `tx_ready`  in  1  consumer accepts byte when `tx_valid && tx_ready`.
- `tx_data`  out  8  response byte, zero-extended RAM data.
- `mem_wr`  out  1  RAM write enable; high ⇒ RAM writes `mem_wdata` at `mem_addr` on next edge.
- `mem_addr`  out  ADDR_WIDTH  RAM address.
- `mem_wdata`  out  DATA_WIDTH  RAM write data.
- `mem_rdata`  in  DATA_WIDTH  RAM read data, combinational from `mem_addr`, valid only while `mem_wr`=0.
- `busy`  out  1  high whenever state ≠ IDLE.
- `err_cnt`  out  8  count of rejected/dropped bytes, saturates at 255.

## Operation
- Command formats (bytes in order): write `0x57`,addr,data; read `0x52`,addr; burst read `0x42`,addr,len → returns len+1 bytes from addr, addr+1, …
- Address byte truncated to low ADDR_WIDTH bits; data byte truncated to low DATA_WIDTH bits.
- States: IDLE, GET_ADDR, GET_LEN, GET_DATA, WRITE, READ, SEND.
- IDLE: on `rx_valid`: 0x57/0x52/0x42 → latch opcode, GET_ADDR; any other byte → `err_cnt`+1, stay.
- GET_ADDR: on `rx_valid` latch addr; W → GET_DATA; R → cnt=0, READ; B → GET_LEN.
- GET_LEN: on `rx_valid` cnt=rx_data → READ.
- GET_DATA: on `rx_valid` latch wdata → WRITE.
- WRITE: `mem_wr`=1 for exactly this one cycle → IDLE.
- READ: `mem_wr`=0; register `tx_data`={0,`mem_rdata`}, set `tx_valid` → SEND.
- SEND: hold `tx_valid`/`tx_data` stable until handshake. On handshake: cnt=0 → IDLE, clear `tx_valid`; else cnt−1, addr+1 modulo 2^ADDR_WIDTH (wraps to 0), clear `tx_valid` → READ.
- `rx_valid` in WRITE, READ or SEND: byte dropped, `err_cnt`+1 (saturating).
- No timeout: a partial command waits indefinitely in GET_*.
- `mem_wr` is decoded from the registered state only; `mem_addr`/`mem_wdata` are registers, stable through WRITE and READ.

## Timing
- Reset (async assert): state IDLE; `tx_valid`=0, `tx_data`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `err_cnt`=0, cnt=0. Outputs reach reset values immediately, without waiting for a clock edge.
- Reset mid-command: command discarded; write not yet in WRITE is never issued; an in-flight `tx_valid` drops immediately.
- Write: final byte strobed in cycle N → `mem_wr` high in N+1 → RAM updated at end of N+1; `busy` low in N+2.
- Read: addr byte in cycle N → READ in N+1 (samples `mem_rdata`) → `tx_valid` high from N+2.
- Burst with `tx_ready` tied high: one byte every 2 cycles (READ, SEND alternate).
- `tx_valid` deasserts the cycle after handshake; never two bytes back-to-back.
- `rx_valid` coincident with the SEND handshake: byte still dropped and counted.

## Test plan
- Write 0x57,0x05,0xA5 then read 0x52,0x05 → exactly one `mem_wr` pulse with addr 5, data 0xA5; one tx byte 0xA5; `err_cnt`=0.
- Burst 0x42,0xFE,0x03 (ADDR_WIDTH=8, RAM preloaded mem[i]=i) → tx bytes 0xFE,0xFF,0x00,0x01 (address wraps); `busy` low after the fourth handshake.
- Hold `tx_ready` low 10 cycles during a read → `tx_valid` and `tx_data` stable all 10 cycles; no further RAM activity until handshake.
- Send 0x00, 0x99, then three bytes during a pending SEND → `err_cnt`=5; 300 bad bytes → `err_cnt`=255.
- Assert `rst_l` low after 0x57,0x10 → no `mem_wr` pulse ever; all outputs at reset values; next 0x52,0x10 returns the prior content.
- ADDR_WIDTH=4, DATA_WIDTH=4: write 0x57,0xF3,0xBC → RAM addr 3 gets 0xC; read back tx byte 0x0C.
